// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with ENABLE, PENDING, CLAIM and COMPLETE registers.
// Define IRQ_CTRL_EDGE_EN for rising-edge source detection; the default build latches sources by level.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               meip_o,
  input  logic               irq_ack_i,
  input  logic               we_i,
  input  logic [1:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_e;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM    = 2'd2;
  localparam logic [1:0] ADDR_COMPLETE = 2'd3;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] detect;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] win_onehot;
  logic [3:0]         claim_q;
  logic [3:0]         win_id;
  logic               ack_take;
  logic               complete_hit;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_prev_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) src_prev_q <= '0;
    else          src_prev_q <= irq_src_i;
  end

  assign detect = irq_src_i & ~src_prev_q;
`else
  assign detect = irq_src_i;
`endif

  assign eligible   = pending_q & enable_q;
  assign win_onehot = eligible & (~eligible + 1'b1);

  // Lowest index wins, so scan downward and let the last hit stick.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i + 1);
    end
  end

  assign ack_take     = (state_q == ASSERT) && irq_ack_i && (eligible != '0);
  assign complete_hit = (state_q == SERVICE) && we_i && (addr_i == ADDR_COMPLETE)
                        && (wdata_i[3:0] == claim_q);
  assign w1c_mask     = (we_i && addr_i == ADDR_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;

  // New detections beat software clears; a claim clears its bit even against a new detection.
  assign pending_d = ((pending_q & ~w1c_mask) | detect) & ~(ack_take ? win_onehot : '0);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_q  <= '0;
      pending_q <= '0;
      claim_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (we_i && addr_i == ADDR_ENABLE) enable_q <= wdata_i[NUM_SRC-1:0];
      if (ack_take)          claim_q <= win_id;
      else if (complete_hit) claim_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (eligible != '0) state_d = ASSERT;
      end
      ASSERT: begin
        if (eligible == '0) state_d = IDLE;
        else if (irq_ack_i) state_d = SERVICE;
      end
      SERVICE: begin
        if (complete_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    meip_o = (state_q == ASSERT);
  end

  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      ADDR_ENABLE:   rdata_o[NUM_SRC-1:0] = enable_q;
      ADDR_PENDING:  rdata_o[NUM_SRC-1:0] = pending_q;
      ADDR_CLAIM:    rdata_o[3:0]         = claim_q;
      ADDR_COMPLETE: rdata_o              = '0;
      default:       rdata_o              = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: NUM_SRC, default 8, number of external interrupt sources (1..15).
REQ-002 Port: clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset_i  input  1  asynchronous, active-low reset.
REQ-004 Port: irq_src_i  input  NUM_SRC  interrupt request lines, synchronous to clk_i.
REQ-005 Port: meip_o  output  1  machine external interrupt pending to the core.
REQ-006 Port: irq_ack_i  input  1  core acknowledge (interrupt taken), one-cycle pulse.
REQ-007 Port: we_i  input  1  register write strobe.
REQ-008 Port: addr_i  input  2  register word index: 0 ENABLE, 1 PENDING, 2 CLAIM, 3 COMPLETE.
REQ-009 Port: wdata_i  input  32  write data.
REQ-010 Port: rdata_o  output  32  combinational read data for addr_i; unused bits 0; COMPLETE reads 0.

Function
REQ-011 Source ID = bit index + 1; ID 0 means none.
REQ-012 ENABLE: RW, bits [NUM_SRC-1:0]; write replaces mask.
REQ-013 PENDING: RO bits; write-1-to-clear per bit; a bit sets in the cycle after its source is detected (see Configuration).
REQ-014 Same-cycle set and W1C on one pending bit: set wins.
REQ-015 Eligible = PENDING & ENABLE; winner = lowest-index eligible bit (fixed priority).
REQ-016 FSM states IDLE, ASSERT, SERVICE.
REQ-017 IDLE -> ASSERT when eligible != 0; meip_o = 1 exactly in ASSERT (registered, one cycle after eligibility).
REQ-018 ASSERT, eligible falls to 0 (mask or W1C) -> IDLE, meip_o low next cycle.
REQ-019 ASSERT, irq_ack_i = 1 -> SERVICE; same edge: CLAIM <= winner ID, winner's PENDING bit cleared (clear beats a same-cycle set of that bit).
REQ-020 SERVICE: meip_o = 0; new pending bits accumulate but do not assert meip_o.
REQ-021 SERVICE, we_i to COMPLETE with wdata_i[3:0] == CLAIM -> IDLE, CLAIM <= 0; mismatching ID ignored.
REQ-022 irq_ack_i in IDLE or SERVICE ignored, no state change.
REQ-023 COMPLETE write outside SERVICE ignored.
REQ-024 CLAIM: RO, holds ID [3:0] during SERVICE, 0 otherwise.

Reset
REQ-025 reset_i low asynchronously forces: IDLE, meip_o 0, ENABLE 0, PENDING 0, CLAIM 0, edge-history 0; rdata_o reflects zeroed registers.
REQ-026 Reset mid-ASSERT or mid-SERVICE discards claim and all pending; first detection after release requires a fresh rising edge (edge mode) or high level (level mode).

Configuration
REQ-027 Macro IRQ_CTRL_EDGE_EN defined: PENDING bit sets on a 0->1 transition of irq_src_i (one-cycle history register); held-high source sets once.
REQ-028 IRQ_CTRL_EDGE_EN undefined: PENDING bit sets every cycle irq_src_i is high (level mode); W1C while source still high re-sets next cycle; no history register.

Verification
REQ-029 ENABLE=0x01, pulse irq_src_i[0] -> PENDING=0x01 next cycle, meip_o=1 following cycle; irq_ack_i -> CLAIM=1, PENDING=0x00, meip_o=0 next cycle.
REQ-030 ENABLE=0xFF, sources 5 and 2 rise same cycle, ack -> CLAIM=3, PENDING=0x20; COMPLETE 3 -> IDLE, meip_o=1 again, second ack -> CLAIM=6.
REQ-031 In SERVICE with CLAIM=1, write COMPLETE 2 -> CLAIM stays 1, meip_o stays 0; write COMPLETE 1 -> CLAIM=0.
REQ-032 In ASSERT, write ENABLE=0 -> meip_o 0 next cycle, state IDLE, PENDING unchanged; re-enable -> meip_o=1.
REQ-033 Edge mode: irq_src_i[4] held high 20 cycles -> PENDING bit 4 set once; W1C -> stays clear. Level mode: same stimulus, W1C -> bit re-sets next cycle.
REQ-034 Assert reset_i low during SERVICE -> meip_o, CLAIM, PENDING, ENABLE all 0 immediately, without a clock edge.
